// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for 640x480@60Hz (defaults) driven by the pixel
//   clock. Upstream of the pattern/colour generator, which consumes
//   hpos/vpos/display_on; hsync/vsync go straight to the pins.
//
//   Every output is a register. The counters and all derived outputs are
//   loaded together from the *next* counter values, so hsync/vsync/
//   display_on/strobes are aligned with the hpos/vpos reported in the same
//   cycle.
//
//   Optional feature (macro VGA_FRAME_COUNTER_EN): adds an 8-bit frame
//   counter output that steps on every frame_start. When the macro is not
//   defined the port and its register do not exist.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   count enable; low freezes timing and clears strobes
//   hpos         out  current column, 0..H_TOTAL-1
//   vpos         out  current line,   0..V_TOTAL-1
//   hsync        out  horizontal sync, active level = SYNC_POL
//   vsync        out  vertical sync,   active level = SYNC_POL
//   display_on   out  high inside the visible window
//   line_start   out  one-cycle strobe when hpos becomes 0
//   frame_start  out  one-cycle strobe when (hpos,vpos) becomes (0,0)
//   frame_cnt    out  frame counter (VGA_FRAME_COUNTER_EN only)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Window bounds are 11 bits wide so an end bound equal to a 1024 total
    // still fits.
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_display_on;
    logic       r_line_start;
    logic       r_frame_start;

    logic [9:0] w_hpos_next;
    logic [9:0] w_vpos_next;
    logic       w_h_wrap;
    logic       w_hsync_act;
    logic       w_vsync_act;
    logic       w_display_next;
    logic       w_line_start_next;
    logic       w_frame_start_next;

    // Next position and everything derived from it.
    always_comb begin
        w_h_wrap    = (r_hpos == H_LAST);
        w_hpos_next = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
        w_vpos_next = r_vpos;
        if (w_h_wrap) begin
            w_vpos_next = (r_vpos == V_LAST) ? 10'd0 : r_vpos + 10'd1;
        end

        w_hsync_act = ({1'b0, w_hpos_next} >= HS_START) &&
                      ({1'b0, w_hpos_next} <  HS_END);
        w_vsync_act = ({1'b0, w_vpos_next} >= VS_START) &&
                      ({1'b0, w_vpos_next} <  VS_END);
        w_display_next     = ({1'b0, w_hpos_next} < H_VIS) &&
                             ({1'b0, w_vpos_next} < V_VIS);
        w_line_start_next  = (w_hpos_next == 10'd0);
        w_frame_start_next = w_line_start_next && (w_vpos_next == 10'd0);
    end

    // Reset parks the counters on the last pixel of the frame so the first
    // enabled edge lands on (0,0) and fires both strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ena) begin
            r_hpos        <= w_hpos_next;
            r_vpos        <= w_vpos_next;
            r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
            r_display_on  <= w_display_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end else begin
            // Frozen: levels hold, strobes drop so a held position never
            // repeats its strobe.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] r_frame_cnt;

    // Steps on the same edge that raises frame_start; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (ena && w_frame_start_next) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share one clock:
//     u_dut_std : default 640x480 timing, active-low sync. Used for reset
//                 values, full-line timing, enable gating at (799,10) and an
//                 async reset at (300,12).
//     u_dut_sm  : shrunken 16x8 raster with active-high sync, so whole
//                 frames (vsync, frame_start, frame counter wrap) fit in a
//                 short run. Random enable and a few random async resets.
//   The reference model tracks a linear pixel index per instance and derives
//   every expected output from the timing parameters with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int S_HV = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 3;
    localparam int S_VV = 4;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;
    localparam int N_CYCLES = 45000;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       rst_n0, ena0, rst_n1, ena1;
    logic [9:0] hpos0, vpos0, hpos1, vpos1;
    logic       hsync0, vsync0, disp0, ls0, fs0;
    logic       hsync1, vsync1, disp1, ls1, fs1;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc0, fc1;
`endif

    vga_timing_gen u_dut_std (
        .clk         (clk),
        .rst_n       (rst_n0),
        .ena         (ena0),
        .hpos        (hpos0),
        .vpos        (vpos0),
        .hsync       (hsync0),
        .vsync       (vsync0),
        .display_on  (disp0),
        .line_start  (ls0),
        .frame_start (fs0)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (fc0)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_POL  (1'b1)
    ) u_dut_sm (
        .clk         (clk),
        .rst_n       (rst_n1),
        .ena         (ena1),
        .hpos        (hpos1),
        .vpos        (vpos1),
        .hsync       (hsync1),
        .vsync       (vsync1),
        .display_on  (disp1),
        .line_start  (ls1),
        .frame_start (fs1)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (fc1)
`endif
    );

    // ---------------- reference model ----------------
    int hv[2], hf[2], hs[2], hb[2], vv[2], vf[2], vs[2], vb[2], pol[2];
    int m_p[2];
    bit m_pre[2];
    bit m_ls[2], m_fs[2];
    int m_fc[2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int h_tot(input int i);
        return hv[i] + hf[i] + hs[i] + hb[i];
    endfunction

    function automatic int v_tot(input int i);
        return vv[i] + vf[i] + vs[i] + vb[i];
    endfunction

    task automatic model_reset(input int i);
        m_pre[i] = 1'b1;
        m_p[i]   = h_tot(i) * v_tot(i) - 1;
        m_ls[i]  = 1'b0;
        m_fs[i]  = 1'b0;
        m_fc[i]  = 0;
    endtask

    // What the next rising edge does to instance i.
    task automatic model_edge(input int i, input bit ena, input bit in_rst);
        if (in_rst) begin
            model_reset(i);
        end else if (ena) begin
            m_p[i]   = (m_p[i] + 1) % (h_tot(i) * v_tot(i));
            m_pre[i] = 1'b0;
            m_ls[i]  = (m_p[i] % h_tot(i)) == 0;
            m_fs[i]  = (m_p[i] == 0);
            if (m_fs[i]) m_fc[i] = (m_fc[i] + 1) % 256;
        end else begin
            m_ls[i] = 1'b0;
            m_fs[i] = 1'b0;
        end
    endtask

    function automatic int model_h(input int i);
        return m_p[i] % h_tot(i);
    endfunction

    function automatic int model_v(input int i);
        return m_p[i] / h_tot(i);
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_inst(input int i);
        logic [9:0] h_d, v_d;
        logic       hs_d, vs_d, d_d, ls_d, fs_d;
        logic [7:0] fc_d;
        int         h, v, e_d, e_hs, e_vs;
        fc_d = 8'd0;
        if (i == 0) begin
            h_d = hpos0; v_d = vpos0; hs_d = hsync0; vs_d = vsync0;
            d_d = disp0; ls_d = ls0; fs_d = fs0;
`ifdef VGA_FRAME_COUNTER_EN
            fc_d = fc0;
`endif
        end else begin
            h_d = hpos1; v_d = vpos1; hs_d = hsync1; vs_d = vsync1;
            d_d = disp1; ls_d = ls1; fs_d = fs1;
`ifdef VGA_FRAME_COUNTER_EN
            fc_d = fc1;
`endif
        end
        h = model_h(i);
        v = model_v(i);
        if (m_pre[i]) begin
            e_d  = 0;
            e_hs = 1 - pol[i];
            e_vs = 1 - pol[i];
        end else begin
            e_d  = (h < hv[i] && v < vv[i]) ? 1 : 0;
            e_hs = (h >= hv[i] + hf[i] && h < hv[i] + hf[i] + hs[i]) ? pol[i] : 1 - pol[i];
            e_vs = (v >= vv[i] + vf[i] && v < vv[i] + vf[i] + vs[i]) ? pol[i] : 1 - pol[i];
        end
        check_eq($sformatf("i%0d_hpos", i), 32'(h_d), 32'(h));
        check_eq($sformatf("i%0d_vpos", i), 32'(v_d), 32'(v));
        check_eq($sformatf("i%0d_hsync", i), 32'(hs_d), 32'(e_hs));
        check_eq($sformatf("i%0d_vsync", i), 32'(vs_d), 32'(e_vs));
        check_eq($sformatf("i%0d_display_on", i), 32'(d_d), 32'(e_d));
        check_eq($sformatf("i%0d_line_start", i), 32'(ls_d), 32'(m_ls[i]));
        check_eq($sformatf("i%0d_frame_start", i), 32'(fs_d), 32'(m_fs[i]));
`ifdef VGA_FRAME_COUNTER_EN
        check_eq($sformatf("i%0d_frame_cnt", i), 32'(fc_d), 32'(m_fc[i]));
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  gate_left;
        bit  gate_done, post_gate, rst0_done, line_checked;
        int  cnt_disp, cnt_hsl, rst_hold0, rst_hold1;
        bit  new_rst0, new_rst1;

        hv = '{640, S_HV}; hf = '{16, S_HF}; hs = '{96, S_HS}; hb = '{48, S_HB};
        vv = '{480, S_VV}; vf = '{10, S_VF}; vs = '{2, S_VS};  vb = '{33, S_VB};
        pol = '{0, 1};

        gate_left = 0; gate_done = 0; post_gate = 0; rst0_done = 0;
        line_checked = 0; cnt_disp = 0; cnt_hsl = 0;
        rst_hold0 = 0; rst_hold1 = 0;

        rst_n0 = 1'b0; rst_n1 = 1'b0; ena0 = 1'b0; ena1 = 1'b0;
        model_reset(0);
        model_reset(1);

        #100;
        @(negedge clk);
        compare_inst(0);
        compare_inst(1);
        check_eq("rst_hpos", 32'(hpos0), 32'd799);
        check_eq("rst_vpos", 32'(vpos0), 32'd524);

        rst_n0 = 1'b1; rst_n1 = 1'b1; ena0 = 1'b1; ena1 = 1'b1;
        model_edge(0, ena0, 1'b0);
        model_edge(1, ena1, 1'b0);

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            compare_inst(0);
            compare_inst(1);

            // Explicit landmarks on the standard instance.
            if (cyc == 0) begin
                check_eq("first_hpos", 32'(hpos0), 32'd0);
                check_eq("first_vpos", 32'(vpos0), 32'd0);
                check_eq("first_display_on", 32'(disp0), 32'd1);
                check_eq("first_frame_start", 32'(fs0), 32'd1);
            end
            if (post_gate) begin
                post_gate = 0;
                check_eq("gate_resume_hpos", 32'(hpos0), 32'd0);
                check_eq("gate_resume_vpos", 32'(vpos0), 32'd11);
                check_eq("gate_resume_line_start", 32'(ls0), 32'd1);
            end
            if (!m_pre[0] && rst_n0 && model_v(0) == 2) begin
                if (disp0) cnt_disp++;
                if (!hsync0) cnt_hsl++;
            end
            if (!line_checked && !m_pre[0] && model_v(0) == 3) begin
                line_checked = 1;
                check_eq("line_display_cycles", 32'(cnt_disp), 32'd640);
                check_eq("line_hsync_cycles", 32'(cnt_hsl), 32'd96);
            end

            // Standard instance: enable gating, then one async reset.
            if (rst_hold0 > 0) begin
                rst_hold0--;
                if (rst_hold0 == 0) rst_n0 = 1'b1;
            end
            if (gate_left > 0) begin
                gate_left--;
                ena0 = (gate_left == 0) ? 1'b0 : 1'b0;
                if (gate_left == 0) begin
                    ena0 = 1'b1;
                    post_gate = 1;
                end
            end else if (!gate_done && !m_pre[0] && model_h(0) == 799 && model_v(0) == 10) begin
                gate_done = 1;
                gate_left = 37;
                ena0 = 1'b0;
            end
            new_rst0 = 0;
            if (gate_done && gate_left == 0 && !rst0_done && rst_n0 && !m_pre[0] &&
                model_h(0) == 300 && model_v(0) == 12) begin
                rst0_done = 1;
                new_rst0 = 1;
            end

            // Small instance: random enable and occasional random reset.
            if (rst_hold1 > 0) begin
                rst_hold1--;
                if (rst_hold1 == 0) rst_n1 = 1'b1;
            end
            ena1 = ($urandom_range(0, 15) != 0);
            new_rst1 = 0;
            if (rst_n1 && cyc > 20 && cyc < 3000 && $urandom_range(0, 499) == 0) new_rst1 = 1;

            // Async resets land between edges and must show before the next one.
            if (new_rst0 || new_rst1) begin
                #2;
                if (new_rst0) begin
                    rst_n0 = 1'b0;
                    model_reset(0);
                    rst_hold0 = 3;
                end
                if (new_rst1) begin
                    rst_n1 = 1'b0;
                    model_reset(1);
                    rst_hold1 = $urandom_range(1, 4);
                end
                #1;
                if (new_rst0) begin
                    compare_inst(0);
                    check_eq("async_rst_hpos", 32'(hpos0), 32'd799);
                    check_eq("async_rst_display_on", 32'(disp0), 32'd0);
                end
                if (new_rst1) compare_inst(1);
            end

            model_edge(0, ena0, !rst_n0);
            model_edge(1, ena1, !rst_n1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
